rgb_mode_sequencer: RTL and testbench

Mode sequencer for the RGB light controller. It registers the 4-bit encoded mode from the user controls (`on`, `up`, `down`, `color`, `fade`, `preset`) and decodes it to a 10-bit one-hot mode vector. It also keeps the brightness level, stepped by an 8-bit add/subtract unit. The one-hot vector and brightness feed the downstream colour-output stage.

---
 rtl/rgb_seq_pkg.sv | 45 ++++
 rtl/rgb_addsub8.sv | 15 +
 rtl/rgb_mode_sequencer.sv | 107 ++++++++++
 tb/tb_rgb_mode_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_seq_pkg.sv
// Shared definitions for the RGB mode sequencer: mode encodings, defaults
// and the bundled control-request type.
package rgb_seq_pkg;

  localparam logic [3:0] MODE_OFF         = 4'b0000;
  localparam logic [3:0] MODE_BRIGHT_UP   = 4'b0001;
  localparam logic [3:0] MODE_BRIGHT_DOWN = 4'b0010;
  localparam logic [3:0] MODE_STEADY      = 4'b0011;
  localparam logic [3:0] MODE_COLOR_SEL   = 4'b0100;
  localparam logic [3:0] MODE_FADE_HOLD   = 4'b0101;
  localparam logic [3:0] MODE_FADE_IN     = 4'b0110;
  localparam logic [3:0] MODE_FADE_OUT    = 4'b0111;
  localparam logic [3:0] MODE_PRESET_1    = 4'b1000;
  localparam logic [3:0] MODE_PRESET_2    = 4'b1001;
  localparam logic [3:0] MODE_PRESET_3    = 4'b1010;

  localparam int BRIGHT_INIT_DEF = 10;
  localparam int BRIGHT_STEP_DEF = 5;
  localparam int PRESET_COUNT    = 3;
  localparam int NUM_MODES       = 10;  // one-hot width (OFF has no bit)

  typedef enum logic [3:0] {
    OFF         = MODE_OFF,
    BRIGHT_UP   = MODE_BRIGHT_UP,
    BRIGHT_DOWN = MODE_BRIGHT_DOWN,
    STEADY      = MODE_STEADY,
    COLOR_SEL   = MODE_COLOR_SEL,
    FADE_HOLD   = MODE_FADE_HOLD,
    FADE_IN     = MODE_FADE_IN,
    FADE_OUT    = MODE_FADE_OUT,
    PRESET_1    = MODE_PRESET_1,
    PRESET_2    = MODE_PRESET_2,
    PRESET_3    = MODE_PRESET_3
  } mode_e;

  typedef struct packed {
    logic       on;
    logic       up;
    logic       down;
    logic [2:0] color;
    logic [1:0] fade;
    logic       preset;
  } ctrl_req_t;

endpackage

// File: rtl/rgb_addsub8.sv
// 8-bit add/subtract unit; subtract is A + ~B + 1, CarryOut is bit 8.
module rgb_addsub8 (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Subtract,
  output logic [7:0] ALU_Out,
  output logic       CarryOut
);

  logic [7:0] b_eff;

  assign b_eff = Subtract ? ~B : B;
  assign {CarryOut, ALU_Out} = {1'b0, A} + {1'b0, b_eff} + {8'd0, Subtract};

endmodule

// File: rtl/rgb_mode_sequencer.sv
// Mode sequencer: registers the encoded light mode, decodes it one-hot and
// steps a saturating brightness level through the add/subtract unit.
module rgb_mode_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int BRIGHT_INIT = BRIGHT_INIT_DEF,
  parameter int BRIGHT_STEP = BRIGHT_STEP_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 on,
  input  logic                 up,
  input  logic                 down,
  input  logic [2:0]           color,
  input  logic [1:0]           fade,
  input  logic                 preset,
  output logic [3:0]           q,
  output logic [NUM_MODES-1:0] t,
  output logic [7:0]           brightness,
  output logic [2:0]           color_q
);

  localparam logic [7:0] STEP8 = 8'(BRIGHT_STEP);
  localparam logic [7:0] INIT8 = 8'(BRIGHT_INIT);

  ctrl_req_t  req;
  mode_e      mode_q, mode_d;
  logic [7:0] alu_out;
  logic       alu_co;
  logic       sub;

  assign req = '{on: on, up: up, down: down, color: color, fade: fade, preset: preset};
  assign q   = mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode_q <= OFF;
    else     mode_q <= mode_d;
  end

  always_comb begin
    mode_d = OFF;
    if (!req.on) begin
      mode_d = OFF;
    end else if (req.preset) begin
      case (mode_q)
        PRESET_1: mode_d = PRESET_2;
        PRESET_2: mode_d = PRESET_3;
        default:  mode_d = PRESET_1;
      endcase
    end else if (req.fade != 2'b00) begin
      case (req.fade)
        2'b01:   mode_d = FADE_IN;
        2'b10:   mode_d = FADE_OUT;
        default: mode_d = FADE_HOLD;
      endcase
    end else if (req.color != 3'b000) begin
      mode_d = COLOR_SEL;
    end else if (req.up ^ req.down) begin
      mode_d = req.up ? BRIGHT_UP : BRIGHT_DOWN;
    end else if (req.up && req.down) begin
      mode_d = STEADY;
    end else begin
      // Fade/preset modes are sticky; everything else settles to STEADY.
      case (mode_q)
        FADE_HOLD, FADE_IN, FADE_OUT,
        PRESET_1, PRESET_2, PRESET_3: mode_d = mode_q;
        default:                      mode_d = STEADY;
      endcase
    end
  end

  // Bit i lights for encoding i+1; encodings above PRESET_3 decode to zero.
  always_comb begin
    t = '0;
    for (int i = 0; i < NUM_MODES; i++)
      t[i] = (q == 4'(i + 1));
  end

  assign sub = (mode_q == BRIGHT_DOWN);

  rgb_addsub8 u_addsub (
    .A        (brightness),
    .B        (STEP8),
    .Subtract (sub),
    .ALU_Out  (alu_out),
    .CarryOut (alu_co)
  );

  // Steps on the current mode, so brightness trails q by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brightness <= INIT8;
    end else begin
      case (mode_q)
        BRIGHT_UP:   brightness <= alu_co ? 8'hFF : alu_out;
        BRIGHT_DOWN: brightness <= alu_co ? alu_out : 8'h00;
        default:     brightness <= brightness;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   color_q <= 3'b111;
    else if (mode_d == COLOR_SEL) color_q <= color;
  end

endmodule

// File: tb/tb_rgb_mode_sequencer.sv
// Scoreboard bench for rgb_mode_sequencer: a behavioural model queues the
// expected outputs for every edge; each scenario pops and compares them.
module tb_rgb_mode_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       on, up, down, preset;
  logic [2:0] color;
  logic [1:0] fade;
  logic [3:0] q;
  logic [9:0] t;
  logic [7:0] brightness;
  logic [2:0] color_q;

  typedef struct {
    logic [3:0] q;
    logic [9:0] t;
    logic [7:0] b;
    logic [2:0] c;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  int         mq;
  int         mb;
  logic [2:0] mc;

  rgb_mode_sequencer #(.BRIGHT_INIT(10), .BRIGHT_STEP(5)) dut (
    .clk(clk), .rst(rst), .on(on), .up(up), .down(down), .color(color),
    .fade(fade), .preset(preset), .q(q), .t(t), .brightness(brightness),
    .color_q(color_q)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] t_of(input int m);
    logic [9:0] r;
    r = '0;
    if (m >= 1 && m <= 10) r[m-1] = 1'b1;
    return r;
  endfunction

  function automatic int model_next(input int cur, input logic o, input logic u,
                                    input logic d, input logic [2:0] c,
                                    input logic [1:0] f, input logic p);
    int s;
    s = (cur > 10) ? 0 : cur;
    if (!o) return 0;
    if (p) return (s == 8) ? 9 : (s == 9) ? 10 : 8;
    if (f == 2'b01) return 6;
    if (f == 2'b10) return 7;
    if (f == 2'b11) return 5;
    if (c != 3'b000) return 4;
    if (u && !d) return 1;
    if (d && !u) return 2;
    if (u && d) return 3;
    if (s >= 5) return s;
    return 3;
  endfunction

  function automatic void model_reset();
    mq = 0; mb = 10; mc = 3'b111;
  endfunction

  // Drive one cycle of inputs, queue the model's prediction, advance an edge.
  task automatic drive(input logic o, input logic u, input logic d,
                       input logic [2:0] c, input logic [1:0] f, input logic p);
    int   nq;
    exp_t x;
    on = o; up = u; down = d; color = c; fade = f; preset = p;
    nq = model_next(mq, o, u, d, c, f, p);
    if (mq == 1) mb = (mb + 5 > 255) ? 255 : mb + 5;
    else if (mq == 2) mb = (mb - 5 < 0) ? 0 : mb - 5;
    if (nq == 4) mc = c;
    mq = nq;
    x.q = 4'(mq); x.t = t_of(mq); x.b = 8'(mb); x.c = mc;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; on = 0; up = 0; down = 0; color = 0; fade = 0; preset = 0;
    model_reset();
    #2;
    n_checks++;
    if ({q, t, brightness, color_q} !== {4'h0, 10'h0, 8'd10, 3'b111}) begin
      n_fail++;
      $display("FAIL reset_init got q=%b t=%b b=%0d c=%b want q=0000 t=0 b=10 c=111",
               q, t, brightness, color_q);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_bright_up();
    for (int i = 0; i < 5; i++) begin
      drive(1, (i < 4), 0, 0, 0, 0);
      e = sb.pop_front();
      n_checks++;
      if ({q, t, brightness, color_q} !== {e.q, e.t, e.b, e.c}) begin
        n_fail++;
        $display("FAIL bright_up[%0d] got q=%b t=%b b=%0d c=%b want q=%b t=%b b=%0d c=%b",
                 i, q, t, brightness, color_q, e.q, e.t, e.b, e.c);
      end
      if (i == 3) begin
        n_checks++;
        if (q !== 4'b0001 || t !== 10'b0000000001 || brightness !== 8'd25) begin
          n_fail++;
          $display("FAIL bright_up_4 got q=%b t=%b b=%0d want q=0001 t=0000000001 b=25",
                   q, t, brightness);
        end
      end
    end
    n_checks++;
    if (q !== 4'b0011) begin
      n_fail++;
      $display("FAIL bright_release got q=%b want 0011", q);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 50; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      e = sb.pop_front();
      n_checks++;
      if ({q, brightness} !== {e.q, e.b}) begin
        n_fail++;
        $display("FAIL sat_up[%0d] got q=%b b=%0d want q=%b b=%0d", i, q, brightness, e.q, e.b);
      end
    end
    n_checks++;
    if (brightness !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_high got b=%0d want 255", brightness);
    end
    for (int i = 0; i < 56; i++) begin
      drive(1, 0, 1, 0, 0, 0);
      e = sb.pop_front();
      n_checks++;
      if ({q, brightness} !== {e.q, e.b}) begin
        n_fail++;
        $display("FAIL sat_down[%0d] got q=%b b=%0d want q=%b b=%0d", i, q, brightness, e.q, e.b);
      end
      if (i == 1) begin
        n_checks++;
        if (brightness !== 8'd250) begin
          n_fail++;
          $display("FAIL sat_first_down got b=%0d want 250", brightness);
        end
      end
    end
    n_checks++;
    if (brightness !== 8'd0 || q !== 4'b0010) begin
      n_fail++;
      $display("FAIL sat_low got q=%b b=%0d want q=0010 b=0", q, brightness);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 1, 0, 3'b101, 0, 0);
    void'(sb.pop_front());
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({q, t, brightness, color_q} !== {4'h0, 10'h0, 8'd10, 3'b111}) begin
      n_fail++;
      $display("FAIL async_reset got q=%b t=%b b=%0d c=%b want q=0000 t=0 b=10 c=111",
               q, t, brightness, color_q);
    end
    model_reset();
    on = 0; up = 0; color = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_priority();
    logic [3:0] wq [3] = '{4'b1000, 4'b0110, 4'b0111};
    logic [9:0] wt [3] = '{10'b0010000000, 10'b0000100000, 10'b0001000000};
    logic [1:0] fv [3] = '{2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 3'b011, fv[i], (i == 0));
      e = sb.pop_front();
      n_checks++;
      if ({q, t} !== {e.q, e.t} || q !== wq[i] || t !== wt[i]) begin
        n_fail++;
        $display("FAIL priority[%0d] got q=%b t=%b want q=%b t=%b", i, q, t, wq[i], wt[i]);
      end
    end
  endtask

  task automatic test_preset_off();
    logic [3:0] wq [4] = '{4'b1000, 4'b1001, 4'b1010, 4'b1000};
    logic [7:0] b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 1);
      e = sb.pop_front();
      n_checks++;
      if ({q, t, brightness} !== {e.q, e.t, e.b} || q !== wq[i]) begin
        n_fail++;
        $display("FAIL preset[%0d] got q=%b want %b", i, q, wq[i]);
      end
    end
    b0 = brightness;
    drive(0, 1, 1, 3'b110, 2'b11, 1);
    e = sb.pop_front();
    n_checks++;
    if (q !== 4'b0000 || t !== 10'd0 || brightness !== b0 || brightness !== e.b) begin
      n_fail++;
      $display("FAIL off_priority got q=%b t=%b b=%0d want q=0000 t=0 b=%0d",
               q, t, brightness, b0);
    end
  endtask

  task automatic test_color();
    logic [2:0] cv [2] = '{3'b010, 3'b000};
    logic [3:0] wq [2] = '{4'b0100, 4'b0011};
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, cv[i], 0, 0);
      e = sb.pop_front();
      n_checks++;
      if ({q, t, color_q} !== {e.q, e.t, e.c} || q !== wq[i] || color_q !== 3'b010) begin
        n_fail++;
        $display("FAIL color[%0d] got q=%b c=%b want q=%b c=010", i, q, color_q, wq[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      drive(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000,
            ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00,
            ($urandom_range(0, 3) == 0));
      e = sb.pop_front();
      n_checks++;
      if ({q, t, brightness, color_q} !== {e.q, e.t, e.b, e.c}) begin
        n_fail++;
        $display("FAIL random[%0d] got q=%b t=%b b=%0d c=%b want q=%b t=%b b=%0d c=%b",
                 i, q, t, brightness, color_q, e.q, e.t, e.b, e.c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bright_up();
    test_saturation();
    test_async_reset();
    test_priority();
    test_preset_off();
    test_color();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
